// File: rtl/wb_conbus_slv_sel.sv
// Slave selector for a shared Wishbone bus. It decodes the top address bits of the
// granted master, locks that slave for the whole cycle, and aborts unmapped or stalled accesses.
module wb_conbus_slv_sel #(
  parameter int S_NUMBER = 6,
  parameter int SEL_BITS = 3,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int TIMEOUT  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   m_cyc_i,
  input  logic                   m_stb_i,
  input  logic [AW-1:0]          m_adr_i,
  output logic                   m_ack_o,
  output logic                   m_err_o,
  output logic                   m_rty_o,
  output logic [DW-1:0]          m_dat_o,
  output logic [S_NUMBER-1:0]    s_cyc_o,
  output logic [S_NUMBER-1:0]    s_stb_o,
  input  logic [S_NUMBER-1:0]    s_ack_i,
  input  logic [S_NUMBER-1:0]    s_err_i,
  input  logic [S_NUMBER-1:0]    s_rty_i,
  input  logic [S_NUMBER*DW-1:0] s_dat_i,
  output logic [SEL_BITS-1:0]    sel_o,
  output logic                   timeout_o,
  output logic [1:0]             state_o
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT - 1);
  localparam logic [SEL_BITS:0] S_LIMIT = (SEL_BITS + 1)'(S_NUMBER);

  typedef enum logic [1:0] {IDLE, ACTIVE, ERR, TMO} state_t;

  state_t              state_q, state_d;
  logic [SEL_BITS-1:0] sel_q, sel_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [SEL_BITS-1:0] adr_idx;
  logic                adr_mapped;
  logic                sl_ack, sl_err, sl_rty;
  logic [DW-1:0]       sl_dat;
  logic [S_NUMBER-1:0] sel_onehot;
  logic                unused_adr;

  assign adr_idx    = m_adr_i[AW-1 -: SEL_BITS];
  assign adr_mapped = ({1'b0, adr_idx} < S_LIMIT);
  assign unused_adr = ^m_adr_i[AW-SEL_BITS-1:0];

  // Mux the locked slave's responses; other slaves' inputs never reach the master.
  always_comb begin
    sl_ack     = 1'b0;
    sl_err     = 1'b0;
    sl_rty     = 1'b0;
    sl_dat     = '0;
    sel_onehot = '0;
    for (int i = 0; i < S_NUMBER; i++) begin
      if (sel_q == SEL_BITS'(i)) begin
        sl_ack        = s_ack_i[i];
        sl_err        = s_err_i[i];
        sl_rty        = s_rty_i[i];
        sl_dat        = s_dat_i[i*DW +: DW];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = '0;
    s_cyc_o   = '0;
    s_stb_o   = '0;
    m_ack_o   = 1'b0;
    m_err_o   = 1'b0;
    m_rty_o   = 1'b0;
    m_dat_o   = '0;
    timeout_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          if (adr_mapped) begin
            sel_d   = adr_idx;
            state_d = ACTIVE;
          end else begin
            state_d = ERR;
          end
        end
      end
      ACTIVE: begin
        s_cyc_o = sel_onehot & {S_NUMBER{m_cyc_i}};
        s_stb_o = sel_onehot & {S_NUMBER{m_stb_i}};
        m_ack_o = sl_ack;
        m_err_o = sl_err;
        m_rty_o = sl_rty;
        m_dat_o = sl_dat;
        // The counter only survives an unterminated strobe; a termination on the limit cycle wins.
        if (!m_cyc_i) begin
          state_d = IDLE;
        end else if (m_stb_i && !(sl_ack || sl_err || sl_rty)) begin
          if (cnt_q == CNT_LIMIT) state_d = TMO;
          else                    cnt_d   = cnt_q + 1'b1;
        end
      end
      ERR: begin
        m_err_o = m_cyc_i;
        state_d = IDLE;
      end
      TMO: begin
        m_err_o   = m_cyc_i;
        timeout_o = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel_o   = sel_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_wb_conbus_slv_sel.sv
// Directed bench for wb_conbus_slv_sel: each step drives inputs on the falling edge,
// queues the expected output vector and checks it just after.
module tb_wb_conbus_slv_sel;

  localparam int NS = 6;
  localparam int SB = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W  = 2*NS + 4 + SB + DW;

  logic            clk, rst_n;
  logic            m_cyc, m_stb;
  logic [AW-1:0]   m_adr;
  logic            m_ack, m_err, m_rty, tmo;
  logic [DW-1:0]   m_dat;
  logic [NS-1:0]   s_cyc, s_stb, s_ack, s_err, s_rty;
  logic [NS*DW-1:0] s_dat;
  logic [SB-1:0]   sel;
  logic [1:0]      state;
  logic [W-1:0]    obs_v;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           checks = 0;
  int           errors = 0;

  wb_conbus_slv_sel #(.S_NUMBER(NS), .SEL_BITS(SB), .AW(AW), .DW(DW), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_adr_i(m_adr),
    .m_ack_o(m_ack), .m_err_o(m_err), .m_rty_o(m_rty), .m_dat_o(m_dat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty), .s_dat_i(s_dat),
    .sel_o(sel), .timeout_o(tmo), .state_o(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs_v = {s_cyc, s_stb, m_ack, m_err, m_rty, tmo, sel, m_dat};

  function automatic logic [W-1:0] ev(input logic [NS-1:0] c, input logic [NS-1:0] s,
                                      input logic a, input logic e, input logic r,
                                      input logic t, input logic [SB-1:0] sl,
                                      input logic [DW-1:0] d);
    return {c, s, a, e, r, t, sl, d};
  endfunction

  task automatic drive(input logic cyc, input logic stb, input logic [AW-1:0] adr);
    m_cyc = cyc;
    m_stb = stb;
    m_adr = adr;
  endtask

  task automatic set_dat(input int idx, input logic [DW-1:0] v);
    s_dat[idx*DW +: DW] = v;
  endtask

  // Called on a falling edge after inputs are driven; returns on the next falling edge.
  task automatic step(input string tag, input logic [W-1:0] exp);
    logic [W-1:0] e;
    string        t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs_v === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, obs_v, e);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0);
    s_ack = '0; s_err = '0; s_rty = '0; s_dat = '0;

    // Reset and idle
    @(negedge clk);
    step("reset", '0);
    rst_n = 1'b1;
    step("idle", '0);

    // Read slave 2; slave 1 chatter must be ignored
    drive(1'b1, 1'b1, 32'h4000_0010);
    step("rd_c0", '0);
    s_ack[1] = 1'b1; set_dat(1, 32'h1111_1111);
    step("rd_c1", ev(6'b000100, 6'b000100, 0, 0, 0, 0, 3'd2, '0));
    step("rd_c2", ev(6'b000100, 6'b000100, 0, 0, 0, 0, 3'd2, '0));
    s_ack = '0; s_ack[2] = 1'b1; set_dat(2, 32'hDEAD_BEEF);
    step("rd_c3_ack", ev(6'b000100, 6'b000100, 1, 0, 0, 0, 3'd2, 32'hDEAD_BEEF));
    s_ack = '0; s_dat = '0;
    drive(1'b0, 1'b0, 32'h4000_0010);
    step("rd_drop", ev('0, '0, 0, 0, 0, 0, 3'd2, '0));
    step("rd_idle", ev('0, '0, 0, 0, 0, 0, 3'd2, '0));

    // Unmapped index 7
    drive(1'b1, 1'b1, 32'hE000_0000);
    step("um_c0", ev('0, '0, 0, 0, 0, 0, 3'd2, '0));
    step("um_err", ev('0, '0, 0, 1, 0, 0, 3'd2, '0));
    drive(1'b0, 1'b0, '0);
    step("um_idle", ev('0, '0, 0, 0, 0, 0, 3'd2, '0));

    // Timeout on slave 1
    drive(1'b1, 1'b1, 32'h2000_0000);
    step("to_c0", ev('0, '0, 0, 0, 0, 0, 3'd2, '0));
    for (int i = 1; i <= 16; i++)
      step($sformatf("to_c%0d", i), ev(6'b000010, 6'b000010, 0, 0, 0, 0, 3'd1, '0));
    step("to_tmo", ev('0, '0, 0, 1, 0, 1, 3'd1, '0));
    drive(1'b0, 1'b0, '0);
    step("to_idle", ev('0, '0, 0, 0, 0, 0, 3'd1, '0));

    // Ack on the limit cycle beats the watchdog
    drive(1'b1, 1'b1, 32'h2000_0000);
    step("lr_c0", ev('0, '0, 0, 0, 0, 0, 3'd1, '0));
    for (int i = 1; i <= 15; i++)
      step($sformatf("lr_c%0d", i), ev(6'b000010, 6'b000010, 0, 0, 0, 0, 3'd1, '0));
    s_ack[1] = 1'b1; set_dat(1, 32'hCAFE_F00D);
    step("lr_ack16", ev(6'b000010, 6'b000010, 1, 0, 0, 0, 3'd1, 32'hCAFE_F00D));
    s_ack = '0; s_dat = '0;
    step("lr_no_tmo", ev(6'b000010, 6'b000010, 0, 0, 0, 0, 3'd1, '0));
    drive(1'b0, 1'b0, '0);
    step("lr_drop", ev('0, '0, 0, 0, 0, 0, 3'd1, '0));
    step("lr_idle", ev('0, '0, 0, 0, 0, 0, 3'd1, '0));

    // Lock: address moves to slave 4 mid-cycle
    drive(1'b1, 1'b1, 32'h2000_0000);
    step("lk_c0", ev('0, '0, 0, 0, 0, 0, 3'd1, '0));
    drive(1'b1, 1'b1, 32'h8000_0000);
    step("lk_c1", ev(6'b000010, 6'b000010, 0, 0, 0, 0, 3'd1, '0));
    drive(1'b1, 1'b0, 32'h8000_0000);
    step("lk_c2", ev(6'b000010, 6'b000000, 0, 0, 0, 0, 3'd1, '0));
    drive(1'b0, 1'b0, 32'h8000_0000);
    step("lk_drop", ev('0, '0, 0, 0, 0, 0, 3'd1, '0));
    drive(1'b1, 1'b1, 32'h8000_0000);
    step("lk_redec", ev('0, '0, 0, 0, 0, 0, 3'd1, '0));
    s_rty[4] = 1'b1;
    step("lk_s4_rty", ev(6'b010000, 6'b010000, 0, 0, 1, 0, 3'd4, '0));
    s_rty = '0;
    drive(1'b0, 1'b0, '0);
    step("lk_end", ev('0, '0, 0, 0, 0, 0, 3'd4, '0));

    // Error pass-through from slave 3, then asynchronous reset mid-transaction
    drive(1'b1, 1'b1, 32'h6000_0000);
    step("rs_c0", ev('0, '0, 0, 0, 0, 0, 3'd4, '0));
    s_err[3] = 1'b1; set_dat(3, 32'h1234_5678);
    step("rs_err3", ev(6'b001000, 6'b001000, 0, 1, 0, 0, 3'd3, 32'h1234_5678));
    rst_n = 1'b0;
    step("rs_async", '0);
    s_err = '0; s_dat = '0;
    drive(1'b0, 1'b0, '0);
    rst_n = 1'b1;
    step("rs_after", '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
